seq_alu_core: RTL and testbench
===============================

SEQ_ALU_CORE -- requirements
Module: seq_alu_core

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, the operand and result width in bits (power of two, 8..64).
REQ-002 The block SHALL have localparam SHW = log2(WIDTH), the shift-amount width.
REQ-003 Port clk, input, 1: sole clock, all state updates on the rising edge.
REQ-004 Port reset, input, 1: reset, synchronous and active-high.
REQ-005 Port in_valid, input, 1: the request fields are valid.
REQ-006 Port in_ready, output, 1: the block accepts a request this cycle.
REQ-007 Port ALUOp, input, 2: operation class from main control.
REQ-008 Port Funct, input, 4: the {funct7[5], funct3} field of the instruction.
REQ-009 Port a, input, WIDTH: operand A.
REQ-010 Port b, input, WIDTH: operand B.
REQ-011 Port out_valid, output, 1: result, zero and op_err are valid.
REQ-012 Port out_ready, input, 1: the consumer takes the result.
REQ-013 Port result, output, WIDTH: operation result.
REQ-014 Port zero, output, 1: high when result == 0.
REQ-015 Port op_err, output, 1: the accepted ALUOp/Funct pair was illegal.

Function
REQ-016 The block SHALL decode operations as follows.
- ALUOp 00 -> ADD.
- ALUOp 01 -> SUB.
- ALUOp 10 with Funct:
  - 0000 ADD, 1000 SUB, 0111 AND, 0110 OR, 0100 XOR, 0010 SLT (signed).
  - 0001 SLL, 0101 SRL, 1101 SRA.
- Any other pair is illegal.
REQ-017 The block SHALL implement a FSM with states IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE.
REQ-018 A request SHALL be accepted on a rising edge where in_valid && in_ready; a, b, ALUOp and Funct SHALL be captured on that edge and ignored afterwards.
REQ-019 ADD, SUB, AND, OR, XOR and SLT SHALL go IDLE->DONE on the accept edge, giving out_valid one cycle after acceptance.
REQ-020 ADD and SUB SHALL wrap modulo 2^WIDTH.
REQ-021 SLT SHALL return 1 zero-extended to WIDTH when signed a < signed b, else 0.
REQ-022 Shifts SHALL use shamt = b[SHW-1:0], and the upper bits of b SHALL be ignored.
REQ-023 A shift with shamt 0 SHALL go to DONE with result = a, giving out_valid one cycle after acceptance.
REQ-024 A shift with shamt > 0 SHALL enter BUSY with a down-counter = shamt.
- Each BUSY cycle shifts by one bit and decrements the counter.
- SRA replicates the MSB; SLL and SRL fill with 0.
- BUSY->DONE occurs on the edge where the counter reaches 0, giving out_valid shamt+1 cycles after acceptance.
REQ-025 An illegal op SHALL go to DONE with result 0 and op_err 1, and zero SHALL be 1 in that case.
REQ-026 In DONE, result, zero, op_err and out_valid SHALL be held stable until out_ready is 1, then the FSM SHALL go DONE->IDLE.
REQ-027 No new request SHALL be accepted in the cycle where DONE is left, so back-to-back throughput is one operation per two cycles minimum.
REQ-028 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE.
REQ-029 zero and op_err SHALL be registered together with result and change only on entry to DONE.

Reset
REQ-030 On reset, the FSM SHALL be in IDLE and the outputs SHALL be: in_ready 1, out_valid 0, result 0, zero 0, op_err 0, shift counter 0.
REQ-031 Reset asserted in BUSY or DONE SHALL discard the operation, and no out_valid for it SHALL ever appear.
REQ-032 Reset SHALL take priority over acceptance on the same edge.

Configuration
REQ-033 The macro SEQ_ALU_MUL_EN SHALL control the multiply feature.
REQ-034 With SEQ_ALU_MUL_EN defined, ALUOp 11 with Funct[2:0]=000 SHALL be MUL.
- Shift-add, one bit of b per BUSY cycle, for exactly WIDTH cycles.
- result = low WIDTH bits of a*b.
- out_valid WIDTH+1 cycles after acceptance.
- Other ALUOp 11 pairs are illegal.
REQ-035 Without SEQ_ALU_MUL_EN, all ALUOp 11 pairs SHALL be illegal (REQ-025), and no multiply hardware SHALL be present.

Verification
REQ-036 WIDTH=64, ALUOp 10 Funct 0000, a=5, b=7, out_ready=1 -> out_valid one cycle after accept, result 12, zero 0; in_ready 1 again the following cycle.
REQ-037 ALUOp 01, a=b=0x1234 -> result 0, zero 1, op_err 0; ALUOp 10 Funct 0010, a=-1, b=1 -> result 1.
REQ-038 ALUOp 10 Funct 1101, a=0x8000_0000_0000_0000, b=0x43 (shamt 3) -> out_valid 4 cycles after accept, result 0xF000_0000_0000_0000; in_ready 0 throughout.
REQ-039 ALUOp 10 Funct 0011 (illegal) -> result 0, zero 1, op_err 1; out_ready held 0 for 5 cycles -> outputs stable, no new accept; out_ready 1 -> IDLE.
REQ-040 SLL with shamt 10, reset pulsed on the 4th BUSY cycle -> IDLE next cycle, out_valid never rises for that op, and the next ADD completes normally.
REQ-041 With SEQ_ALU_MUL_EN, ALUOp 11 Funct 0000, a=3, b=0xFFFF_FFFF_FFFF_FFFF -> result 0xFFFF_FFFF_FFFF_FFFD after 65 cycles; without the macro -> op_err 1 after 1 cycle.

Source files
------------

// File: rtl/seq_alu_core.sv
// Sequential ALU: single-cycle arithmetic/logic, bit-serial shifts, optional shift-add multiply.
// Define SEQ_ALU_MUL_EN to enable MUL on ALUOp 11 (Funct[2:0] == 000); otherwise ALUOp 11 is illegal.
module seq_alu_core #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUOp,
    input  logic [3:0]       Funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             op_err
);

    localparam int SHW = $clog2(WIDTH);
    // One extra bit so the counter can hold WIDTH for the multiply.
    localparam int CW  = SHW + 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
`ifdef SEQ_ALU_MUL_EN
    localparam logic [CW-1:0] MUL_CNT = CW'(WIDTH);
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA, SH_MUL} kind_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT,
        OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_ILL
    } op_t;

    state_t           state_reg, state_next;
    kind_t            kind_reg, kind_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             zero_reg, zero_next;
    logic             err_reg, err_next;
`ifdef SEQ_ALU_MUL_EN
    logic [WIDTH-1:0] mcand_reg, mcand_next;
    logic [WIDTH-1:0] mplier_reg, mplier_next;
`endif

    op_t              dec_op;
    logic [WIDTH-1:0] alu_val;
    logic [WIDTH-1:0] step_val;
    logic [SHW-1:0]   shamt;

    assign shamt = b[SHW-1:0];

    always_comb begin
        dec_op = OP_ILL;
        case (ALUOp)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                case (Funct)
                    4'b0000: dec_op = OP_ADD;
                    4'b1000: dec_op = OP_SUB;
                    4'b0111: dec_op = OP_AND;
                    4'b0110: dec_op = OP_OR;
                    4'b0100: dec_op = OP_XOR;
                    4'b0010: dec_op = OP_SLT;
                    4'b0001: dec_op = OP_SLL;
                    4'b0101: dec_op = OP_SRL;
                    4'b1101: dec_op = OP_SRA;
                    default: dec_op = OP_ILL;
                endcase
            end
            default: begin
`ifdef SEQ_ALU_MUL_EN
                if (Funct[2:0] == 3'b000) begin
                    dec_op = OP_MUL;
                end
`endif
            end
        endcase
    end

    always_comb begin
        alu_val = '0;
        case (dec_op)
            OP_ADD:  alu_val = a + b;
            OP_SUB:  alu_val = a - b;
            OP_AND:  alu_val = a & b;
            OP_OR:   alu_val = a | b;
            OP_XOR:  alu_val = a ^ b;
            OP_SLT:  alu_val = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_val = '0;
        endcase
    end

    // One bit of work per BUSY cycle.
    always_comb begin
        step_val = acc_reg;
        case (kind_reg)
            SH_SLL:  step_val = {acc_reg[WIDTH-2:0], 1'b0};
            SH_SRL:  step_val = {1'b0, acc_reg[WIDTH-1:1]};
            SH_SRA:  step_val = {acc_reg[WIDTH-1], acc_reg[WIDTH-1:1]};
`ifdef SEQ_ALU_MUL_EN
            SH_MUL:  step_val = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
`endif
            default: step_val = acc_reg;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        kind_next   = kind_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        zero_next   = zero_reg;
        err_next    = err_reg;
`ifdef SEQ_ALU_MUL_EN
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    case (dec_op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: begin
                            result_next = alu_val;
                            zero_next   = (alu_val == '0);
                            err_next    = 1'b0;
                            state_next  = DONE;
                        end
                        OP_SLL, OP_SRL, OP_SRA: begin
                            kind_next = (dec_op == OP_SLL) ? SH_SLL :
                                        (dec_op == OP_SRL) ? SH_SRL : SH_SRA;
                            if (shamt == '0) begin
                                result_next = a;
                                zero_next   = (a == '0);
                                err_next    = 1'b0;
                                state_next  = DONE;
                            end else begin
                                acc_next   = a;
                                cnt_next   = {1'b0, shamt};
                                state_next = BUSY;
                            end
                        end
`ifdef SEQ_ALU_MUL_EN
                        OP_MUL: begin
                            kind_next   = SH_MUL;
                            acc_next    = '0;
                            mcand_next  = a;
                            mplier_next = b;
                            cnt_next    = MUL_CNT;
                            state_next  = BUSY;
                        end
`endif
                        default: begin
                            result_next = '0;
                            zero_next   = 1'b1;
                            err_next    = 1'b1;
                            state_next  = DONE;
                        end
                    endcase
                end
            end
            BUSY: begin
                acc_next = step_val;
                cnt_next = cnt_reg - CNT_ONE;
`ifdef SEQ_ALU_MUL_EN
                mcand_next  = {mcand_reg[WIDTH-2:0], 1'b0};
                mplier_next = {1'b0, mplier_reg[WIDTH-1:1]};
`endif
                // The last step lands directly in the result register.
                if (cnt_reg <= CNT_ONE) begin
                    cnt_next    = '0;
                    result_next = step_val;
                    zero_next   = (step_val == '0);
                    err_next    = 1'b0;
                    state_next  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            kind_reg   <= SH_SLL;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            zero_reg   <= 1'b0;
            err_reg    <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            mcand_reg  <= '0;
            mplier_reg <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            kind_reg   <= kind_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
            zero_reg   <= zero_next;
            err_reg    <= err_next;
`ifdef SEQ_ALU_MUL_EN
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
`endif
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign result    = result_reg;
    assign zero      = zero_reg;
    assign op_err    = err_reg;

endmodule

// File: tb/tb_seq_alu_core.sv
// Directed bench for seq_alu_core (WIDTH=64): latency, results, hold behaviour and reset abort.
module tb_seq_alu_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  aluop;
    logic [3:0]  funct;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        zero;
    logic        op_err;

    int          vectors    = 0;
    int          miscompares = 0;
    int          lat;
    logic        rdy_seen;
    logic [63:0] res_s;
    logic        z_s;
    logic        e_s;
    logic        ov_seen;

    seq_alu_core #(.WIDTH(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ALUOp    (aluop),
        .Funct    (funct),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .zero     (zero),
        .op_err   (op_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("wait_idle_timeout", {63'd0, in_ready}, 64'd1);
    endtask

    // Issue one request with out_ready high; measure cycles from accept edge to out_valid.
    task automatic run_op(input logic [1:0] op, input logic [3:0] f,
                          input logic [63:0] av, input logic [63:0] bv);
        out_ready = 1'b1;
        wait_idle();
        aluop    = op;
        funct    = f;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = ~av;
        b        = ~bv;
        lat      = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 200) begin
            rdy_seen |= in_ready;
            @(posedge clk);
            #1;
            lat++;
        end
        rdy_seen |= in_ready;
        res_s = result;
        z_s   = zero;
        e_s   = op_err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        aluop     = 2'b00;
        funct     = 4'b0000;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result",    result,             64'd0);
        chk("rst_zero",      {63'd0, zero},      64'd0);
        chk("rst_op_err",    {63'd0, op_err},    64'd0);
        @(negedge clk);
        reset = 1'b0;

        // ADD via R-type, then in_ready returns the following cycle
        run_op(2'b10, 4'b0000, 64'd5, 64'd7);
        chk("add_lat",    lat,   64'd1);
        chk("add_result", res_s, 64'd12);
        chk("add_zero",   {63'd0, z_s}, 64'd0);
        chk("add_err",    {63'd0, e_s}, 64'd0);
        @(posedge clk);
        #1;
        chk("add_rdy_next", {63'd0, in_ready},  64'd1);
        chk("add_ov_next",  {63'd0, out_valid}, 64'd0);

        run_op(2'b01, 4'b1111, 64'h1234, 64'h1234);
        chk("sub_eq_result", res_s, 64'd0);
        chk("sub_eq_zero",   {63'd0, z_s}, 64'd1);
        chk("sub_eq_err",    {63'd0, e_s}, 64'd0);

        run_op(2'b10, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        chk("slt_neg_result", res_s, 64'd1);
        run_op(2'b10, 4'b0010, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("slt_pos_result", res_s, 64'd0);
        chk("slt_pos_zero",   {63'd0, z_s}, 64'd1);

        run_op(2'b00, 4'b0101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        chk("add_wrap", res_s, 64'd1);
        run_op(2'b01, 4'b0000, 64'd0, 64'd1);
        chk("sub_wrap", res_s, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(2'b10, 4'b1000, 64'd10, 64'd3);
        chk("sub_rtype", res_s, 64'd7);
        run_op(2'b10, 4'b0111, 64'hF0F0, 64'hFF00);
        chk("and", res_s, 64'hF000);
        run_op(2'b10, 4'b0110, 64'hF0F0, 64'hFF00);
        chk("or",  res_s, 64'hFFF0);
        run_op(2'b10, 4'b0100, 64'hF0F0, 64'hFF00);
        chk("xor", res_s, 64'h0FF0);

        // SRA, shamt 3 taken from b[5:0] of 0x43
        run_op(2'b10, 4'b1101, 64'h8000_0000_0000_0000, 64'h43);
        chk("sra_lat",    lat,   64'd4);
        chk("sra_result", res_s, 64'hF000_0000_0000_0000);
        chk("sra_rdy",    {63'd0, rdy_seen}, 64'd0);

        run_op(2'b10, 4'b0101, 64'h8000_0000_0000_0000, 64'h104);
        chk("srl_lat",    lat,   64'd5);
        chk("srl_result", res_s, 64'h0800_0000_0000_0000);

        run_op(2'b10, 4'b0001, 64'h1234, 64'h40);
        chk("sll0_lat",    lat,   64'd1);
        chk("sll0_result", res_s, 64'h1234);

        run_op(2'b10, 4'b0001, 64'd1, 64'd63);
        chk("sll63_lat",    lat,   64'd64);
        chk("sll63_result", res_s, 64'h8000_0000_0000_0000);

        // Illegal op held in DONE while a new request is offered
        wait_idle();
        aluop     = 2'b10;
        funct     = 4'b0011;
        a         = 64'd5;
        b         = 64'd6;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        aluop = 2'b00;
        a     = 64'd1;
        b     = 64'd1;
        chk("ill_flags",  {60'd0, out_valid, zero, op_err, in_ready}, 64'b1110);
        chk("ill_result", result, 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("ill_hold_flags",  {60'd0, out_valid, zero, op_err, in_ready}, 64'b1110);
            chk("ill_hold_result", result, 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ill_leave_ov",  {63'd0, out_valid}, 64'd0);
        chk("ill_leave_rdy", {63'd0, in_ready},  64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("ill_no_accept", {63'd0, out_valid}, 64'd0);

        // Reset on the 4th BUSY cycle of a 10-bit SLL
        wait_idle();
        aluop    = 2'b10;
        funct    = 4'b0001;
        a        = 64'd1;
        b        = 64'd10;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rstbusy_rdy", {63'd0, in_ready},  64'd1);
        chk("rstbusy_ov",  {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        reset   = 1'b0;
        ov_seen = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            ov_seen |= out_valid;
        end
        chk("rstbusy_no_ov", {63'd0, ov_seen}, 64'd0);
        run_op(2'b00, 4'b0000, 64'd100, 64'd23);
        chk("rstbusy_add_lat",    lat,   64'd1);
        chk("rstbusy_add_result", res_s, 64'd123);

        // Reset wins over a simultaneous accept
        wait_idle();
        aluop    = 2'b00;
        a        = 64'd1;
        b        = 64'd2;
        in_valid = 1'b1;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_prio_ov",  {63'd0, out_valid}, 64'd0);
        chk("rst_prio_res", result, 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;

`ifdef SEQ_ALU_MUL_EN
        run_op(2'b11, 4'b0000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("mul_lat",    lat,   64'd65);
        chk("mul_result", res_s, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("mul_err",    {63'd0, e_s}, 64'd0);
        run_op(2'b11, 4'b0001, 64'd3, 64'd5);
        chk("mul_ill_err", {63'd0, e_s}, 64'd1);
`else
        run_op(2'b11, 4'b0000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("op11_lat",    lat,   64'd1);
        chk("op11_err",    {63'd0, e_s}, 64'd1);
        chk("op11_result", res_s, 64'd0);
        chk("op11_zero",   {63'd0, z_s}, 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
